lc3_mem_arbiter: RTL and testbench

- Shares the single LC-3 memory port between instruction fetch (fetch stage) and data access (memory stage: LD/LDR/LDI/ST/STR/STI).
- Arbitrates between the two requesters, sequences one memory transaction at a time with a variable-latency ready handshake, and returns read data.
- Drives the pipeline-wide stall signal while any request is unserved.
- Data accesses have priority; a starvation counter guarantees forward progress for fetch.

---
 rtl/lc3_mem_arbiter_pkg.sv | 17 +
 rtl/lc3_mem_prio_pick.sv | 23 ++
 rtl/lc3_mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_lc3_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_mem_arbiter_pkg.sv
// Shared types and constants for the LC-3 memory-port arbiter.
package lc3_mem_arbiter_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

    // Width of the fetch-starvation counter; STARVE_MAX must fit in it.
    localparam int unsigned STARVE_W = 3;

endpackage

// File: rtl/lc3_mem_prio_pick.sv
// Combinational winner select between fetch and data requesters.
module lc3_mem_prio_pick
    import lc3_mem_arbiter_pkg::*;
(
    input  logic   if_elig_i,
    input  logic   dm_elig_i,
    input  logic   fetch_due_i,
    output logic   grant_o,
    output owner_e owner_o,
    output logic   contested_o
);

    // Data wins ties unless fetch has been passed over too often.
    always_comb begin
        grant_o     = if_elig_i | dm_elig_i;
        contested_o = if_elig_i & dm_elig_i;
        owner_o     = OWN_IF;
        if (dm_elig_i && !(if_elig_i && fetch_due_i)) begin
            owner_o = OWN_DM;
        end
    end

endmodule

// File: rtl/lc3_mem_arbiter.sv
// Shares the single LC-3 memory port between instruction fetch and data
// access, one transaction at a time, with data priority and a starvation
// guard for fetch.
module lc3_mem_arbiter
    import lc3_mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_valid,
    output logic [15:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [15:0] dm_addr,
    input  logic [15:0] dm_wdata,
    output logic        dm_valid,
    output logic [15:0] dm_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic        stall
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    logic [15:0]         addr_q, addr_d;
    logic                we_q, we_d;
    logic [15:0]         wdata_q, wdata_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic [15:0]         if_rdata_q, if_rdata_d;
    logic [15:0]         dm_rdata_q, dm_rdata_d;
    logic                if_valid_q, if_valid_d;
    logic                dm_valid_q, dm_valid_d;

    logic   if_elig, dm_elig;
    logic   grant, contested;
    owner_e pick_owner;

    // A requester being acknowledged this cycle is not eligible again yet.
    always_comb begin
        if_elig = if_req & ~if_valid_q;
        dm_elig = dm_req & ~dm_valid_q;
    end

    lc3_mem_prio_pick u_pick (
        .if_elig_i   (if_elig),
        .dm_elig_i   (dm_elig),
        .fetch_due_i (starve_q == STARVE_LIM),
        .grant_o     (grant),
        .owner_o     (pick_owner),
        .contested_o (contested)
    );

    // Next-state: grant and latch in IDLE, complete on mem_ready in ACCESS.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        starve_d   = starve_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        if_valid_d = 1'b0;
        dm_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    state_d = ST_ACCESS;
                    owner_d = pick_owner;
                    if (pick_owner == OWN_DM) begin
                        addr_d  = dm_addr;
                        we_d    = dm_we;
                        wdata_d = dm_wdata;
                        if (contested && (starve_q != STARVE_LIM)) begin
                            starve_d = starve_q + STARVE_W'(1);
                        end
                    end else begin
                        addr_d   = if_addr;
                        we_d     = 1'b0;
                        starve_d = '0;
                    end
                end
            end
            ST_ACCESS: begin
                if (mem_ready) begin
                    state_d = ST_IDLE;
                    if (owner_q == OWN_IF) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = mem_rdata;
                    end else begin
                        dm_valid_d = 1'b1;
                        if (!we_q) begin
                            dm_rdata_d = mem_rdata;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_IF;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            starve_q   <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            starve_q   <= starve_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            if_valid_q <= if_valid_d;
            dm_valid_q <= dm_valid_d;
        end
    end

    // Memory-side outputs come only from registered state.
    always_comb begin
        mem_en    = (state_q == ST_ACCESS);
        mem_we    = mem_en & we_q & (owner_q == OWN_DM);
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if_valid  = if_valid_q;
        dm_valid  = dm_valid_q;
        if_rdata  = if_rdata_q;
        dm_rdata  = dm_rdata_q;
        stall     = (if_req & ~if_valid_q) | (dm_req & ~dm_valid_q);
    end

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Bench for lc3_mem_arbiter: two instances (STARVE_MAX 4 and 0) share one
// stimulus stream and are compared every cycle against a rule-level model.
module tb_lc3_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, dm_req, dm_we, mem_ready;
    logic [15:0] if_addr, dm_addr, dm_wdata, mem_rdata;

    logic [1:0]  if_valid, dm_valid, mem_en, mem_we, stall;
    logic [15:0] if_rdata [2];
    logic [15:0] dm_rdata [2];
    logic [15:0] mem_addr [2];
    logic [15:0] mem_wdata[2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lc3_mem_arbiter #(.STARVE_MAX(4)) dut0 (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid[0]), .if_rdata(if_rdata[0]),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_valid(dm_valid[0]), .dm_rdata(dm_rdata[0]),
        .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall(stall[0])
    );

    lc3_mem_arbiter #(.STARVE_MAX(0)) dut1 (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid[1]), .if_rdata(if_rdata[1]),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_valid(dm_valid[1]), .dm_rdata(dm_rdata[1]),
        .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall(stall[1])
    );

    task automatic chk(input string name, input int d, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", name, d, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    int          sm [2] = '{4, 0};
    bit          m_busy[2], m_isdm[2], m_we[2], m_ifv[2], m_dmv[2];
    logic [15:0] m_addr[2], m_wd[2], m_ifrd[2], m_dmrd[2];
    int          m_passed[2];   // contests data has won since fetch was last served
    bit          chk_on = 1'b0;

    task automatic model_step();
        bit nif, ndm, fe, de;
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                m_busy[d] = 0; m_isdm[d] = 0; m_we[d] = 0; m_ifv[d] = 0; m_dmv[d] = 0;
                m_addr[d] = '0; m_wd[d] = '0; m_ifrd[d] = '0; m_dmrd[d] = '0; m_passed[d] = 0;
            end else begin
                nif = 0; ndm = 0;
                if (m_busy[d]) begin
                    if (mem_ready) begin
                        m_busy[d] = 0;
                        if (m_isdm[d]) begin
                            ndm = 1;
                            if (!m_we[d]) m_dmrd[d] = mem_rdata;
                        end else begin
                            nif = 1;
                            m_ifrd[d] = mem_rdata;
                        end
                    end
                end else begin
                    fe = if_req && !m_ifv[d];
                    de = dm_req && !m_dmv[d];
                    if (fe && (!de || m_passed[d] >= sm[d])) begin
                        m_busy[d] = 1; m_isdm[d] = 0; m_we[d] = 0; m_addr[d] = if_addr; m_passed[d] = 0;
                    end else if (de) begin
                        m_busy[d] = 1; m_isdm[d] = 1; m_we[d] = dm_we; m_addr[d] = dm_addr; m_wd[d] = dm_wdata;
                        if (fe) m_passed[d]++;
                    end
                end
                m_ifv[d] = nif;
                m_dmv[d] = ndm;
            end
        end
    endtask

    task automatic model_check();
        for (int d = 0; d < 2; d++) begin
            chk("m.mem_en",   d, 16'(mem_en[d]),   16'(m_busy[d]));
            chk("m.mem_we",   d, 16'(mem_we[d]),   16'(m_busy[d] && m_isdm[d] && m_we[d]));
            if (m_busy[d]) chk("m.mem_addr", d, mem_addr[d], m_addr[d]);
            if (m_busy[d] && m_isdm[d] && m_we[d]) chk("m.mem_wdata", d, mem_wdata[d], m_wd[d]);
            chk("m.if_valid", d, 16'(if_valid[d]), 16'(m_ifv[d]));
            chk("m.dm_valid", d, 16'(dm_valid[d]), 16'(m_dmv[d]));
            chk("m.if_rdata", d, if_rdata[d], m_ifrd[d]);
            chk("m.dm_rdata", d, dm_rdata[d], m_dmrd[d]);
            chk("m.stall",    d, 16'(stall[d]),
                16'((if_req && !m_ifv[d]) || (dm_req && !m_dmv[d])));
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_on) model_check();
    end

    // ---------------- grant logger (owner read from the address nibble) ----------------
    bit  log_on = 1'b0;
    bit  prev_en[2];
    byte glog0[$];
    byte glog1[$];

    initial forever begin
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (log_on && mem_en[d] && !prev_en[d]) begin
                if (d == 0) glog0.push_back((mem_addr[0][15:12] == 4'h3) ? "I" : "D");
                else        glog1.push_back((mem_addr[1][15:12] == 4'h3) ? "I" : "D");
            end
            prev_en[d] = mem_en[d];
        end
    end

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic        ifr;  logic [15:0] ifa;
        logic        dmr;  logic        dmwe; logic [15:0] dma; logic [15:0] dmwd;
        logic        rdy;  logic [15:0] rd;
        logic        e_en; logic        e_we; logic [15:0] e_addr;
        logic        e_ifv; logic       e_dmv;
        logic [15:0] e_ifrd; logic [15:0] e_dmrd;
        logic        e_stall;
    } vec_t;

    localparam int NV = 22;
    vec_t vt [NV];

    task automatic set_in(input logic ifr, input logic dmr, input logic rdy);
        if_req = ifr; dm_req = dmr; mem_ready = rdy;
    endtask

    string exp0, exp1;

    initial begin
        // fetch 3000 -> 1234, zero-wait
        vt[0]  = '{1,16'h3000, 0,0,16'h0000,16'h0000, 0,16'h0000, 0,0,16'h0000, 0,0, 16'h0000,16'h0000, 1};
        vt[1]  = '{1,16'h3000, 0,0,16'h0000,16'h0000, 1,16'h1234, 1,0,16'h3000, 0,0, 16'h0000,16'h0000, 1};
        vt[2]  = '{1,16'h3000, 0,0,16'h0000,16'h0000, 0,16'h0000, 0,0,16'h0000, 1,0, 16'h1234,16'h0000, 0};
        vt[3]  = '{0,16'h0000, 0,0,16'h0000,16'h0000, 0,16'h0000, 0,0,16'h0000, 0,0, 16'h1234,16'h0000, 0};
        // load 4100 -> A5A5
        vt[4]  = '{0,16'h0000, 1,0,16'h4100,16'h0000, 0,16'h0000, 0,0,16'h0000, 0,0, 16'h1234,16'h0000, 1};
        vt[5]  = '{0,16'h0000, 1,0,16'h4100,16'h0000, 1,16'hA5A5, 1,0,16'h4100, 0,0, 16'h1234,16'h0000, 1};
        vt[6]  = '{0,16'h0000, 1,0,16'h4100,16'h0000, 0,16'h0000, 0,0,16'h0000, 0,1, 16'h1234,16'hA5A5, 0};
        vt[7]  = '{0,16'h0000, 0,0,16'h0000,16'h0000, 0,16'h0000, 0,0,16'h0000, 0,0, 16'h1234,16'hA5A5, 0};
        // store BEEF to 4000, memory slow for 3 cycles; dm_rdata must stay A5A5
        vt[8]  = '{0,16'h0000, 1,1,16'h4000,16'hBEEF, 0,16'h0000, 0,0,16'h0000, 0,0, 16'h1234,16'hA5A5, 1};
        vt[9]  = '{0,16'h0000, 1,1,16'h4000,16'hBEEF, 0,16'h0000, 1,1,16'h4000, 0,0, 16'h1234,16'hA5A5, 1};
        vt[10] = '{0,16'h0000, 1,1,16'h4000,16'hBEEF, 0,16'h0000, 1,1,16'h4000, 0,0, 16'h1234,16'hA5A5, 1};
        vt[11] = '{0,16'h0000, 1,1,16'h4000,16'hBEEF, 0,16'h0000, 1,1,16'h4000, 0,0, 16'h1234,16'hA5A5, 1};
        vt[12] = '{0,16'h0000, 1,1,16'h4000,16'hBEEF, 1,16'h1111, 1,1,16'h4000, 0,0, 16'h1234,16'hA5A5, 1};
        vt[13] = '{0,16'h0000, 1,1,16'h4000,16'hBEEF, 0,16'h0000, 0,0,16'h0000, 0,1, 16'h1234,16'hA5A5, 0};
        vt[14] = '{0,16'h0000, 0,0,16'h0000,16'h0000, 0,16'h0000, 0,0,16'h0000, 0,0, 16'h1234,16'hA5A5, 0};
        // back-to-back loads 5000 then 5001; address switches in the dm_valid cycle
        vt[15] = '{0,16'h0000, 1,0,16'h5000,16'h0000, 0,16'h0000, 0,0,16'h0000, 0,0, 16'h1234,16'hA5A5, 1};
        vt[16] = '{0,16'h0000, 1,0,16'h5000,16'h0000, 1,16'h0500, 1,0,16'h5000, 0,0, 16'h1234,16'hA5A5, 1};
        vt[17] = '{0,16'h0000, 1,0,16'h5001,16'h0000, 0,16'h0000, 0,0,16'h0000, 0,1, 16'h1234,16'h0500, 0};
        vt[18] = '{0,16'h0000, 1,0,16'h5001,16'h0000, 0,16'h0000, 0,0,16'h0000, 0,0, 16'h1234,16'h0500, 1};
        vt[19] = '{0,16'h0000, 1,0,16'h5001,16'h0000, 1,16'h0501, 1,0,16'h5001, 0,0, 16'h1234,16'h0500, 1};
        vt[20] = '{0,16'h0000, 1,0,16'h5001,16'h0000, 0,16'h0000, 0,0,16'h0000, 0,1, 16'h1234,16'h0501, 0};
        vt[21] = '{0,16'h0000, 0,0,16'h0000,16'h0000, 0,16'h0000, 0,0,16'h0000, 0,0, 16'h1234,16'h0501, 0};

        reset = 1; if_req = 0; dm_req = 0; dm_we = 0; mem_ready = 0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
        step();
        chk_on = 1;
        step();
        reset = 0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst.mem_en",   d, 16'(mem_en[d]), 16'h0);
            chk("rst.mem_addr", d, mem_addr[d],    16'h0);
            chk("rst.if_valid", d, 16'(if_valid[d]), 16'h0);
            chk("rst.dm_valid", d, 16'(dm_valid[d]), 16'h0);
            chk("rst.if_rdata", d, if_rdata[d],    16'h0);
            chk("rst.dm_rdata", d, dm_rdata[d],    16'h0);
            chk("rst.stall",    d, 16'(stall[d]),  16'h0);
        end
        step();

        for (int i = 0; i < NV; i++) begin
            if_req = vt[i].ifr; if_addr = vt[i].ifa;
            dm_req = vt[i].dmr; dm_we = vt[i].dmwe; dm_addr = vt[i].dma; dm_wdata = vt[i].dmwd;
            mem_ready = vt[i].rdy; mem_rdata = vt[i].rd;
            @(negedge clk);
            chk("vec.mem_en",   i, 16'(mem_en[0]),   16'(vt[i].e_en));
            chk("vec.mem_we",   i, 16'(mem_we[0]),   16'(vt[i].e_we));
            if (vt[i].e_en) chk("vec.mem_addr",  i, mem_addr[0],  vt[i].e_addr);
            if (vt[i].e_we) chk("vec.mem_wdata", i, mem_wdata[0], vt[i].dmwd);
            chk("vec.if_valid", i, 16'(if_valid[0]), 16'(vt[i].e_ifv));
            chk("vec.dm_valid", i, 16'(dm_valid[0]), 16'(vt[i].e_dmv));
            chk("vec.if_rdata", i, if_rdata[0],      vt[i].e_ifrd);
            chk("vec.dm_rdata", i, dm_rdata[0],      vt[i].e_dmrd);
            chk("vec.stall",    i, 16'(stall[0]),    16'(vt[i].e_stall));
            step();
        end

        // reset while an access is waiting on memory
        if_addr = 16'h3ABC; set_in(1, 0, 0);
        step();
        @(negedge clk); chk("rstacc.mem_en_before", 0, 16'(mem_en[0]), 16'h1);
        step();
        reset = 1;
        step();
        reset = 0;
        @(negedge clk);
        chk("rstacc.mem_en_after", 0, 16'(mem_en[0]),   16'h0);
        chk("rstacc.if_valid",     0, 16'(if_valid[0]), 16'h0);
        chk("rstacc.stall",        0, 16'(stall[0]),    16'h1);
        step();
        mem_ready = 1; mem_rdata = 16'h7777;
        @(negedge clk);
        chk("rstacc.regrant_en",   0, 16'(mem_en[0]), 16'h1);
        chk("rstacc.regrant_addr", 0, mem_addr[0],    16'h3ABC);
        step();
        mem_ready = 0;
        @(negedge clk);
        chk("rstacc.if_valid_after", 0, 16'(if_valid[0]), 16'h1);
        chk("rstacc.if_rdata_after", 0, if_rdata[0],      16'h7777);
        step();
        set_in(0, 0, 0);
        step();

        // starvation: repeated contests from a quiet bus; fetch withdraws when it loses
        reset = 1; step(); reset = 0; step();
        log_on = 1;
        if_addr = 16'h3000; dm_we = 0;
        for (int r = 0; r < 6; r++) begin
            dm_addr = 16'h4000 + 16'(r);
            set_in(1, 1, 0); step();
            set_in(0, 1, 1); step();
            set_in(0, 1, 1); step();
            set_in(0, 0, 1); step();
            set_in(0, 0, 1); step();
            set_in(0, 0, 0); step();
        end
        step();
        log_on = 0;
        exp0 = "DDDDIDD";
        exp1 = "IDIDIDIDIDID";
        chk("starve.len", 0, 16'(glog0.size()), 16'(exp0.len()));
        for (int i = 0; i < exp0.len(); i++)
            chk("starve.grant", 0, (i < glog0.size()) ? 16'(glog0[i]) : 16'h0, 16'(exp0[i]));
        chk("starve.len", 1, 16'(glog1.size()), 16'(exp1.len()));
        for (int i = 0; i < exp1.len(); i++)
            chk("starve.grant", 1, (i < glog1.size()) ? 16'(glog1[i]) : 16'h0, 16'(exp1[i]));

        // randomized traffic; requesters follow the handshake of dut0
        for (int c = 0; c < 3000; c++) begin
            if (if_req && if_valid[0]) if_req = 0;
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1; if_addr = {4'h3, 12'($urandom)};
            end
            if (dm_req && dm_valid[0]) dm_req = 0;
            if (!dm_req && $urandom_range(0, 2) == 0) begin
                dm_req = 1; dm_we = 1'($urandom); dm_addr = {4'h4, 12'($urandom)}; dm_wdata = 16'($urandom);
            end
            mem_ready = 1'($urandom);
            mem_rdata = 16'($urandom);
            reset     = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
